// File: rtl/sr_fifo_arbiter_if.sv
// sr_fifo_arbiter_if: producer/consumer handshake and FIFO strobe bundle for the shared CPU FIFO arbiter.
interface sr_fifo_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int CNT_W     = $clog2(DEPTH) + 1
);
  logic                  flush;
  logic                  cpu_push_req;
  logic [DATA_WIDTH-1:0] cpu_push_data;
  logic                  ext_push_valid;
  logic [DATA_WIDTH-1:0] ext_push_data;
  logic                  ext_push_ready;
  logic                  cpu_pop_req;
  logic                  fifo_write_enable;
  logic [DATA_WIDTH-1:0] fifo_write_data;
  logic                  fifo_read_enable;
  logic                  fifo_flush;
  logic                  cpu_stall;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  modport master (
    output flush, cpu_push_req, cpu_push_data, ext_push_valid, ext_push_data, cpu_pop_req,
    input  ext_push_ready, fifo_write_enable, fifo_write_data, fifo_read_enable, fifo_flush,
           cpu_stall, count, full, empty
  );
  modport slave (
    input  flush, cpu_push_req, cpu_push_data, ext_push_valid, ext_push_data, cpu_pop_req,
    output ext_push_ready, fifo_write_enable, fifo_write_data, fifo_read_enable, fifo_flush,
           cpu_stall, count, full, empty
  );
endinterface

// File: rtl/sr_fifo_arbiter.sv
// sr_fifo_arbiter: round-robin write-port arbiter, occupancy tracker and stall generator for the shared CPU FIFO.
module sr_fifo_arbiter #(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input logic           clk,
  input logic           reset,
  sr_fifo_arbiter_if.slave bus
);
  logic [CNT_W-1:0] r_count;
  logic             r_rr;
  logic             w_full;
  logic             w_empty;
  logic             w_pop_ok;
  logic             w_can_push;
  logic             w_cpu_gnt;
  logic             w_ext_gnt;
  logic             w_push;
  logic [CNT_W-1:0] w_count_next;
  assign w_full       = r_count == CNT_W'(DEPTH);
  assign w_empty      = r_count == '0;
  assign w_pop_ok     = ~reset & bus.cpu_pop_req & ~w_empty & ~bus.flush;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign w_can_push   = ~reset & ~bus.flush & (~w_full | w_pop_ok);
  assign w_cpu_gnt    = w_can_push & bus.cpu_push_req & (~bus.ext_push_valid | ~r_rr);
  assign w_ext_gnt    = w_can_push & bus.ext_push_valid & (~bus.cpu_push_req | r_rr);
  assign w_push       = w_cpu_gnt | w_ext_gnt;
  assign w_count_next = bus.flush ? '0
                      : r_count + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop_ok};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_rr    <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_push) r_rr <= w_cpu_gnt;
    end
  end
  assign bus.ext_push_ready    = w_ext_gnt;
  assign bus.fifo_write_enable = w_push;
  assign bus.fifo_write_data   = w_ext_gnt ? bus.ext_push_data : bus.cpu_push_data;
  assign bus.fifo_read_enable  = w_pop_ok;
  assign bus.fifo_flush        = ~reset & bus.flush;
  assign bus.cpu_stall         = ~reset & ~bus.flush
                               & ((bus.cpu_push_req & ~w_cpu_gnt) | (bus.cpu_pop_req & ~w_pop_ok));
  assign bus.count             = r_count;
  assign bus.full              = w_full;
  assign bus.empty             = w_empty;
endmodule

// File: tb/tb_sr_fifo_arbiter.sv
// tb_sr_fifo_arbiter: directed-vector bench for sr_fifo_arbiter at DEPTH=4.
module tb_sr_fifo_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  sr_fifo_arbiter_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();
  sr_fifo_arbiter #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic cp, input logic [31:0] cd, input logic ev, input logic [31:0] ed,
                       input logic pp, input logic fl);
    bus.cpu_push_req   = cp;
    bus.cpu_push_data  = cd;
    bus.ext_push_valid = ev;
    bus.ext_push_data  = ed;
    bus.cpu_pop_req    = pp;
    bus.flush          = fl;
    #1;
  endtask
  task automatic strobes(input string tag, input logic we, input logic rdy, input logic re,
                         input logic st);
    chk({tag, ".we"}, 32'(bus.fifo_write_enable), 32'(we));
    chk({tag, ".rdy"}, 32'(bus.ext_push_ready), 32'(rdy));
    chk({tag, ".re"}, 32'(bus.fifo_read_enable), 32'(re));
    chk({tag, ".stall"}, 32'(bus.cpu_stall), 32'(st));
  endtask
  task automatic edge_cnt(input string tag, input int exp);
    @(posedge clk);
    #1;
    chk({tag, ".count"}, 32'(bus.count), 32'(exp));
    @(negedge clk);
  endtask
  initial begin
    drive(1'b1, 32'hA1, 1'b1, 32'h77, 1'b1, 1'b0);
    strobes("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.flush", 32'(bus.fifo_flush), 32'd0);
    chk("rst.count", 32'(bus.count), 32'd0);
    chk("rst.empty", 32'(bus.empty), 32'd1);
    chk("rst.full", 32'(bus.full), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // 1: two CPU pushes
    drive(1'b1, 32'hA1, 1'b0, 32'h0, 1'b0, 1'b0);
    strobes("t1a", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1a.wd", bus.fifo_write_data, 32'hA1);
    edge_cnt("t1a", 1);
    drive(1'b1, 32'hA2, 1'b0, 32'h0, 1'b0, 1'b0);
    strobes("t1b", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1b.wd", bus.fifo_write_data, 32'hA2);
    edge_cnt("t1b", 2);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    strobes("drain1", 1'b0, 1'b0, 1'b1, 1'b0);
    edge_cnt("drain1", 1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    edge_cnt("drain2", 0);
    // 2: pop from empty stalls, ext push fills, pop completes
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    strobes("t2a", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2a.empty", 32'(bus.empty), 32'd1);
    edge_cnt("t2a", 0);
    drive(1'b0, 32'h0, 1'b1, 32'h55, 1'b1, 1'b0);
    strobes("t2b", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t2b.wd", bus.fifo_write_data, 32'h55);
    edge_cnt("t2b", 1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    strobes("t2c", 1'b0, 1'b0, 1'b1, 1'b0);
    edge_cnt("t2c", 0);
    // 3: contention from empty alternates CPU, EXT, CPU, EXT
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hC0 + 32'(i), 1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
      strobes($sformatf("t3_%0d", i), 1'b1, i[0], 1'b0, i[0]);
      chk($sformatf("t3_%0d.wd", i), bus.fifo_write_data, i[0] ? 32'hE0 + 32'(i) : 32'hC0 + 32'(i));
      edge_cnt($sformatf("t3_%0d", i), i + 1);
    end
    chk("t3.full", 32'(bus.full), 32'd1);
    // 4: full with push+pop, then push alone stalls
    drive(1'b1, 32'hB4, 1'b0, 32'h0, 1'b1, 1'b0);
    strobes("t4a", 1'b1, 1'b0, 1'b1, 1'b0);
    edge_cnt("t4a", 4);
    drive(1'b1, 32'hB5, 1'b0, 32'h0, 1'b0, 1'b0);
    strobes("t4b", 1'b0, 1'b0, 1'b0, 1'b1);
    edge_cnt("t4b", 4);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    edge_cnt("t5pre", 3);
    // 5: flush overrides a CPU push
    drive(1'b1, 32'hF5, 1'b0, 32'h0, 1'b0, 1'b1);
    strobes("t5", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5.flush", 32'(bus.fifo_flush), 32'd1);
    edge_cnt("t5", 0);
    // 6: async reset mid-cycle at count 2
    drive(1'b1, 32'h61, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_cnt("t6a", 1);
    drive(1'b1, 32'h62, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_cnt("t6b", 2);
    drive(1'b1, 32'h63, 1'b1, 32'h64, 1'b1, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("t6.count", 32'(bus.count), 32'd0);
    chk("t6.empty", 32'(bus.empty), 32'd1);
    strobes("t6", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_cnt("t6post", 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
